// File: rtl/flp_burst_gen.sv
// Fast/Normal Link Pulse transmitter for the auto-negotiation front end.
// Emits bursts of 17 clock pulses interleaved with 16 Link Code Word data
// pulses (FLP), or a single pulse per period (NLP), with a fixed
// start-to-start burst period.
module flp_burst_gen #(
    parameter int PULSE_W      = 2,
    parameter int HALF_SLOT    = 1000,
    parameter int BURST_PERIOD = 256000,
    parameter int DIFF_DRIVE   = 0
) (
    input  logic        CLK16,
    input  logic        RSTn,
    input  logic        enable,
    input  logic        mode,
    input  logic [15:0] lcw,
    output logic        TXp,
    output logic        TXm,
    output logic        busy,
    output logic        burst_start,
    output logic        lcw_taken,
    output logic [7:0]  burst_cnt
);

    localparam int SLOT_W = (HALF_SLOT > 1) ? $clog2(HALF_SLOT) : 1;
    localparam int PER_W  = (BURST_PERIOD > 1) ? $clog2(BURST_PERIOD) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(HALF_SLOT - 1);
    localparam logic [SLOT_W-1:0] PULSE_END = SLOT_W'(PULSE_W);
    localparam logic [SLOT_W-1:0] TAIL_END  = SLOT_W'(2 * PULSE_W);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(BURST_PERIOD - 1);

    // Position numbers: even = clock pulse, odd = LCW data bit (pos-1)/2.
    localparam logic [5:0] FLP_LAST_POS = 6'd32;
    localparam logic [5:0] NLP_LAST_POS = 6'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOT = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SLOT_W-1:0] slot_q,  slot_d;
    logic [PER_W-1:0]  per_q,   per_d;
    logic [5:0]        pos_q,   pos_d;
    logic [15:0]       lcw_q,   lcw_d;
    logic              mode_q,  mode_d;
    logic              txp_q,   txp_d;
    logic              txm_q,   txm_d;
    logic              busy_q,  busy_d;
    logic              start_q, start_d;
    logic              taken_q, taken_d;
    logic [7:0]        cnt_q,   cnt_d;

    logic [5:0] last_pos;
    logic       emit;
    logic       launch;

    // Next-state logic: slot/position sequencing, period timing and pulse shaping.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        slot_d  = slot_q;
        per_d   = per_q;
        pos_d   = pos_q;
        lcw_d   = lcw_q;
        mode_d  = mode_q;
        txp_d   = 1'b0;
        txm_d   = 1'b0;
        start_d = 1'b0;
        taken_d = 1'b0;
        cnt_d   = cnt_q;
        launch  = 1'b0;

        last_pos = mode_q ? FLP_LAST_POS : NLP_LAST_POS;
        // Clock positions always fire; data positions fire only on a 1 bit.
        emit     = pos_q[0] ? lcw_q[pos_q[4:1]] : 1'b1;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    launch = 1'b1;
                end
            end
            SLOT: begin
                per_d = per_q + PER_W'(1);
                // The pulse occupies the first PULSE_W slot cycles; the output
                // register delays it by one cycle onto start+1..start+PULSE_W.
                txp_d = emit && (slot_q < PULSE_END);
                txm_d = (DIFF_DRIVE != 0) && emit &&
                        (slot_q >= PULSE_END) && (slot_q < TAIL_END);
                if (slot_q == SLOT_LAST) begin
                    slot_d = '0;
                    if (pos_q == last_pos) begin
                        state_d = GAP;
                    end else begin
                        pos_d = pos_q + 6'd1;
                    end
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
            GAP: begin
                if (per_q == PER_LAST) begin
                    if (enable) begin
                        launch = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    per_d = per_q + PER_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Burst start (t0): inputs are sampled here and held until the next t0.
        if (launch) begin
            state_d = SLOT;
            slot_d  = '0;
            per_d   = '0;
            pos_d   = '0;
            mode_d  = mode;
            if (mode) begin
                lcw_d = lcw;
            end
            taken_d = mode;
            start_d = 1'b1;
            cnt_d   = cnt_q + 8'd1;
        end

        busy_d = (state_d == SLOT);
    end

    // State and output registers; reset clears line drive immediately.
    always_ff @(posedge CLK16 or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            slot_q  <= '0;
            per_q   <= '0;
            pos_q   <= '0;
            lcw_q   <= '0;
            mode_q  <= 1'b0;
            txp_q   <= 1'b0;
            txm_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            taken_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the same pre-edge values regardless of statement order.
            state_q <= state_d;
            slot_q  <= slot_d;
            per_q   <= per_d;
            pos_q   <= pos_d;
            lcw_q   <= lcw_d;
            mode_q  <= mode_d;
            txp_q   <= txp_d;
            txm_q   <= txm_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
        end
    end

    assign TXp         = txp_q;
    assign TXm         = txm_q;
    assign busy        = busy_q;
    assign burst_start = start_q;
    assign lcw_taken   = taken_q;
    assign burst_cnt   = cnt_q;

endmodule

// File: tb/tb_flp_burst_gen.sv
// Bench for flp_burst_gen: two instances (single-ended and differential
// drive) share stimulus and are compared every cycle against a model that
// derives outputs from burst start times and slot arithmetic.
module tb_flp_burst_gen;

    localparam int PW = 2;
    localparam int HS = 12;
    localparam int BP = 416;

    logic        clk;
    logic        rst_n;
    logic        en_r;
    logic        mode_r;
    logic [15:0] lcw_r;

    logic txp0, txm0, busy0, start0, taken0;
    logic txp1, txm1, busy1, start1, taken1;
    logic [7:0] cnt0, cnt1;

    flp_burst_gen #(.PULSE_W(PW), .HALF_SLOT(HS), .BURST_PERIOD(BP), .DIFF_DRIVE(0)) u_dut0 (
        .CLK16(clk), .RSTn(rst_n), .enable(en_r), .mode(mode_r), .lcw(lcw_r),
        .TXp(txp0), .TXm(txm0), .busy(busy0), .burst_start(start0),
        .lcw_taken(taken0), .burst_cnt(cnt0)
    );

    flp_burst_gen #(.PULSE_W(PW), .HALF_SLOT(HS), .BURST_PERIOD(BP), .DIFF_DRIVE(1)) u_dut1 (
        .CLK16(clk), .RSTn(rst_n), .enable(en_r), .mode(mode_r), .lcw(lcw_r),
        .TXp(txp1), .TXm(txm1), .busy(busy1), .burst_start(start1),
        .lcw_taken(taken1), .burst_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a burst is described only by its start cycle and
    // the inputs captured there.
    longint      cyc     = 0;
    longint      t0      = 0;
    bit          have_t0 = 0;
    bit          active  = 0;
    bit          m_mode  = 0;
    logic [15:0] m_lcw   = '0;
    int          m_cnt   = 0;

    // Observed statistics for directed checks (taken from dut0).
    int     obs_pulses = 0;
    int     obs_busy   = 0;
    int     obs_starts = 0;
    int     obs_taken  = 0;
    bit     prev_txp   = 0;
    longint start_times[$];

    bit e_txp, e_txm;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic start_burst();
        have_t0 = 1;
        active  = 1;
        t0      = cyc;
        m_mode  = mode_r;
        if (mode_r) m_lcw = lcw_r;
        m_cnt   = (m_cnt + 1) % 256;
    endtask

    task automatic model_reset();
        have_t0 = 0;
        active  = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        cyc++;
        if (!rst_n) return;
        if (!active) begin
            if (en_r) start_burst();
        end else if (cyc - t0 == BP) begin
            if (en_r) start_burst();
            else active = 0;
        end
    endtask

    task automatic compare_all();
        bit     e_start, e_taken, e_busy, hit;
        longint d, q, r;
        int     last;
        e_start = 0; e_taken = 0; e_busy = 0; e_txp = 0; e_txm = 0;
        if (have_t0) begin
            last    = m_mode ? 32 : 0;
            d       = cyc - t0;
            e_start = (d == 0);
            e_taken = e_start && m_mode;
            e_busy  = (d < (last + 1) * HS);
            if (d >= 1) begin
                q = (d - 1) / HS;
                r = (d - 1) % HS;
                if (q <= last) begin
                    hit   = (q % 2 == 0) || m_lcw[int'((q - 1) / 2)];
                    e_txp = hit && (r < PW);
                    e_txm = hit && (r >= PW) && (r < 2 * PW);
                end
            end
        end
        check("txp0",   32'(txp0),   32'(e_txp));
        check("txm0",   32'(txm0),   32'd0);
        check("busy0",  32'(busy0),  32'(e_busy));
        check("start0", 32'(start0), 32'(e_start));
        check("taken0", 32'(taken0), 32'(e_taken));
        check("cnt0",   32'(cnt0),   32'(m_cnt));
        check("txp1",   32'(txp1),   32'(e_txp));
        check("txm1",   32'(txm1),   32'(e_txm));
        check("busy1",  32'(busy1),  32'(e_busy));
        check("cnt1",   32'(cnt1),   32'(m_cnt));
        check("overlap1", 32'(txp1 & txm1), 32'd0);

        if (txp0 && !prev_txp) obs_pulses++;
        prev_txp = txp0;
        if (busy0)  obs_busy++;
        if (taken0) obs_taken++;
        if (start0) begin
            obs_starts++;
            start_times.push_back(cyc);
        end
    endtask

    task automatic clear_stats();
        obs_pulses = 0;
        obs_busy   = 0;
        obs_starts = 0;
        obs_taken  = 0;
        start_times.delete();
    endtask

    // One cycle: model advances on the edge, outputs checked on the falling
    // edge, then optional random input changes for the next edge.
    task automatic run_cycles(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
            if (rnd) begin
                if ($urandom_range(199) == 0) en_r   = ~en_r;
                if ($urandom_range(99)  == 0) mode_r = ~mode_r;
                if ($urandom_range(49)  == 0) lcw_r  = 16'($urandom);
            end
        end
    endtask

    initial begin
        bit seen;
        rst_n  = 1'b0;
        en_r   = 1'b0;
        mode_r = 1'b0;
        lcw_r  = 16'h0000;

        // Reset state.
        run_cycles(3, 0);
        rst_n = 1'b1;
        run_cycles(2, 0);

        // FLP with the reference LCW: 17 clock + 6 data pulses.
        en_r = 1'b1; mode_r = 1'b1; lcw_r = 16'h41E1;
        clear_stats();
        run_cycles(BP, 0);
        check("flp_pulses", 32'(obs_pulses), 32'd23);
        check("flp_busy_len", 32'(obs_busy), 32'(33 * HS));
        run_cycles(2 * BP, 0);
        check("flp_starts", 32'(obs_starts), 32'd3);
        check("flp_cnt", 32'(cnt0), 32'd3);
        if (start_times.size() == 3) begin
            check("flp_spacing_a", 32'(start_times[1] - start_times[0]), 32'(BP));
            check("flp_spacing_b", 32'(start_times[2] - start_times[1]), 32'(BP));
        end

        // LCW change after t0 affects only the following burst.
        lcw_r = 16'hFFFF;
        clear_stats();
        run_cycles(5 * HS, 0);
        lcw_r = 16'h0000;
        run_cycles(BP - 5 * HS, 0);
        check("lcw_hold_pulses", 32'(obs_pulses), 32'd33);
        clear_stats();
        run_cycles(BP, 0);
        check("lcw_zero_pulses", 32'(obs_pulses), 32'd17);

        // NLP: one pulse per period, no LCW capture.
        mode_r = 1'b0;
        lcw_r  = 16'hA5A5;
        clear_stats();
        run_cycles(3 * BP, 0);
        check("nlp_pulses", 32'(obs_pulses), 32'd3);
        check("nlp_taken", 32'(obs_taken), 32'd0);
        check("nlp_starts", 32'(obs_starts), 32'd3);

        // Disable mid-burst: burst finishes, no further start, returns idle.
        mode_r = 1'b1;
        lcw_r  = 16'h0000;
        clear_stats();
        run_cycles(10 * HS, 0);
        en_r = 1'b0;
        run_cycles(2 * BP - 10 * HS, 0);
        check("dis_pulses", 32'(obs_pulses), 32'd17);
        check("dis_starts", 32'(obs_starts), 32'd1);
        check("dis_busy_end", 32'(busy0), 32'd0);

        // Re-enable from idle, then randomized operation.
        en_r = 1'b1;
        run_cycles(20 * BP, 1);

        // Reset asserted in the middle of a pulse.
        en_r = 1'b1; mode_r = 1'b1; lcw_r = 16'hFFFF;
        seen = 0;
        for (int i = 0; i < 3 * BP && !seen; i++) begin
            run_cycles(1, 0);
            if (e_txp) seen = 1;
        end
        check("rst_pulse_found", 32'(seen), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_txp0", 32'(txp0), 32'd0);
        check("rst_txp1", 32'(txp1), 32'd0);
        check("rst_txm1", 32'(txm1), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_cnt",  32'(cnt0), 32'd0);
        model_reset();
        run_cycles(3, 0);
        rst_n = 1'b1;
        clear_stats();
        run_cycles(BP, 0);
        check("post_rst_pulses", 32'(obs_pulses), 32'd33);
        check("post_rst_cnt", 32'(cnt0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/flp_burst_gen.md
Name: flp_burst_gen

Overview:
Parametrised Fast Link Pulse (FLP) / Normal Link Pulse (NLP) transmitter for the 10/100BASE-T auto-negotiation front end. It emits IEEE 802.3 clause 28 style bursts of 17 clock pulses interleaved with 16 Link Code Word (LCW) data pulses, repeated at a fixed start-to-start period. It adds runtime LCW loading, NLP fallback mode, clean enable/disable at burst boundaries, an optional negative tail lobe, and status strobes. It sits between the auto-negotiation control logic and the TXp/TXm line-driver pins.

Parameters:
PULSE_W, 2, width of a link pulse in CLK cycles (2 cycles = 125 ns at 16 MHz)
HALF_SLOT, 1000, cycles between successive pulse positions (62.5 us at 16 MHz)
BURST_PERIOD, 256000, start-to-start burst period in cycles (16 ms at 16 MHz); must exceed 33*HALF_SLOT
DIFF_DRIVE, 0, 1 = drive a TXm tail lobe after each TXp pulse; 0 = TXm held low

Ports:
CLK16  input  1  sole clock; all logic on posedge
RSTn  input  1  asynchronous, active-low reset
enable  input  1  1 = generate link pulses
mode  input  1  1 = FLP bursts, 0 = NLP single pulses
lcw  input  16  Link Code Word; bit 0 is transmitted first
TXp  output  1  positive line drive, registered
TXm  output  1  negative line drive, registered
busy  output  1  high from burst start until its last pulse slot ends
burst_start  output  1  one-cycle strobe when a burst or NLP starts
lcw_taken  output  1  one-cycle strobe when lcw is latched (FLP mode only)
burst_cnt  output  8  count of bursts started; wraps 255->0

Behaviour:
- Reset (RSTn low, asynchronous): TXp, TXm, busy, burst_start, lcw_taken = 0; burst_cnt = 0; state = IDLE; all timers = 0. If reset occurs mid-pulse, TXp and TXm drop immediately, with no partial-pulse completion.
- States: IDLE, SLOT, GAP.
- IDLE -> SLOT: on the first edge with enable = 1. That cycle is t0. At t0, burst_start = 1, mode is latched, and in FLP mode lcw is latched with lcw_taken = 1. burst_cnt increments.
- Pulse positions in FLP mode: k = 0..32. Position k begins at t0 + k*HALF_SLOT.
  - Even k is a clock pulse and is always emitted.
  - Odd k is data bit (k-1)/2 and is emitted only if that latched LCW bit is 1.
- Pulse timing: an emitted pulse at position k drives TXp = 1 for cycles start+1 .. start+PULSE_W (one cycle of register latency).
- Tail lobe: if DIFF_DRIVE = 1, TXm = 1 for the PULSE_W cycles immediately after the TXp pulse. Otherwise TXm = 0 always. TXp and TXm are never high together.
- NLP mode: only position 0 is used, so there is one pulse per period.
- SLOT -> GAP: after position 32 (FLP) or position 0 (NLP) completes its HALF_SLOT window. busy falls on entering GAP.
- GAP -> SLOT: when the period counter reaches BURST_PERIOD-1 and enable = 1. The next t0 is exactly BURST_PERIOD cycles after the previous t0.
- GAP -> IDLE: when the period counter expires with enable = 0.
- Disabling: enable deasserting during SLOT or GAP never truncates a burst. The current burst completes and the period finishes; no new burst starts.
- Input stability: lcw and mode changes after t0 are ignored until the next t0.
- Counter widths: the period counter is wide enough for BURST_PERIOD-1 (18 bits at default). The slot counter is wide enough for HALF_SLOT-1. The position counter is 6 bits.
- Simultaneous events: enable re-asserting in the same cycle the period expires starts a new burst with no IDLE cycle.

Test Plan:
- Reset, enable = 1, mode = 1, lcw = 16'h41E1 -> burst_start at t0, 23 TXp pulses each 2 cycles wide. Clock pulses start at t0+1+2000*n. Data pulses appear at positions 1, 11, 13, 15, 17, 29. busy is high for 33000 cycles.
- Steady FLP, 3 bursts -> burst_start spacing is exactly 256000 cycles; burst_cnt reads 1, 2, 3.
- mode = 0 -> one 2-cycle TXp pulse per 256000 cycles; lcw_taken never asserted.
- lcw changed from 16'hFFFF to 16'h0000 at t0+5000 -> that burst still carries 33 pulses; the following burst carries 17.
- enable dropped at t0+10000 -> the burst completes all positions, then no burst_start at t0+256000 and the state returns to IDLE. RSTn pulsed low mid-pulse -> TXp = 0 asynchronously and burst_cnt = 0.
- DIFF_DRIVE = 1 -> TXm high for cycles start+3..start+4 of every pulse; TXp and TXm are never high in the same cycle.
